// File: rtl/pipe_reg_pkg.sv
// Shared constants and helpers for the pipeline register chain.
// Holds default widths, the maximum chain depth and the ctrl masking helper.
package pipe_reg_pkg;

    localparam int DEF_CTRL_W = 16;
    localparam int DEF_DATA_W = 96;
    localparam int MAX_DEPTH  = 4;

    // Clears every ctrl bit whose mask bit is set.
    function automatic logic [63:0] mask_ctrl(
        input logic [63:0] ctrl,
        input logic [63:0] mask
    );
        return ctrl & ~mask;
    endfunction

endpackage

// File: rtl/pipe_reg_slot.sv
// One register stage of the chain: hold, bubble insertion or pass-through.
// Ports: clock, reset, hold, bubble, src_ctrl/data/valid in; ctrl_o/data_o/valid_o out.
module pipe_reg_slot
    import pipe_reg_pkg::*;
#(
    parameter int                CTRL_W      = DEF_CTRL_W,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter logic [CTRL_W-1:0] BUBBLE_MASK = '1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic              bubble,
    input  logic [CTRL_W-1:0] src_ctrl,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (!hold) begin
            // Data always follows the source so a bubble keeps the
            // restart PC and similar fields for exception reporting.
            data_d = src_data;
            if (bubble) begin
                ctrl_d  = CTRL_W'(mask_ctrl(64'(src_ctrl), 64'(BUBBLE_MASK)));
                valid_d = 1'b0;
            end else begin
                ctrl_d  = src_ctrl;
                valid_d = src_valid;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline register chain with per-stage stall, flush and entry cancel.
// Ports: clock, reset, in_ctrl, in_data, in_stall, in_cancel, stall, flush in;
// out_ctrl, out_data, stage_valid out. PIPE_REG_CHAIN_PERF_EN adds perf counters.
module pipe_reg_chain
    import pipe_reg_pkg::*;
#(
    parameter int                CTRL_W      = DEF_CTRL_W,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                DEPTH       = 1,
    parameter logic [CTRL_W-1:0] BUBBLE_MASK = '1,
    parameter logic [CTRL_W-1:0] CANCEL_MASK = CTRL_W'(1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_stall,
    input  logic              in_cancel,
    input  logic [DEPTH-1:0]  stall,
    input  logic [DEPTH-1:0]  flush,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [DEPTH-1:0]  stage_valid
`ifdef PIPE_REG_CHAIN_PERF_EN
    ,
    output logic [31:0]       perf_hold_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    logic [CTRL_W-1:0] st_ctrl [DEPTH];
    logic [DATA_W-1:0] st_data [DEPTH];
    logic [DEPTH-1:0]  st_valid;
    logic [DEPTH-1:0]  hold;
    logic [DEPTH-1:0]  bub;
    logic [CTRL_W-1:0] entry_ctrl;

    // A stall at any later stage backs up every earlier stage.
    always_comb begin
        hold = '0;
        hold[DEPTH-1] = stall[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i+1];
        end
    end

    // A held upstream stage cannot hand over its item, so the
    // next stage takes a bubble instead of a duplicate.
    always_comb begin
        bub = '0;
        bub[0] = in_stall | flush[0];
        for (int i = 1; i < DEPTH; i++) begin
            bub[i] = hold[i-1] | flush[i];
        end
    end

    assign entry_ctrl = in_cancel
        ? CTRL_W'(mask_ctrl(64'(in_ctrl), 64'(CANCEL_MASK)))
        : in_ctrl;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [CTRL_W-1:0] s_ctrl;
        logic [DATA_W-1:0] s_data;
        logic              s_valid;

        if (i == 0) begin : g_head
            assign s_ctrl  = entry_ctrl;
            assign s_data  = in_data;
            assign s_valid = 1'b1;
        end else begin : g_body
            assign s_ctrl  = st_ctrl[i-1];
            assign s_data  = st_data[i-1];
            assign s_valid = st_valid[i-1];
        end

        pipe_reg_slot #(
            .CTRL_W      (CTRL_W),
            .DATA_W      (DATA_W),
            .BUBBLE_MASK (BUBBLE_MASK)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .hold      (hold[i]),
            .bubble    (bub[i]),
            .src_ctrl  (s_ctrl),
            .src_data  (s_data),
            .src_valid (s_valid),
            .ctrl_o    (st_ctrl[i]),
            .data_o    (st_data[i]),
            .valid_o   (st_valid[i])
        );
    end

    assign out_ctrl    = st_ctrl[DEPTH-1];
    assign out_data    = st_data[DEPTH-1];
    assign stage_valid = st_valid;

`ifdef PIPE_REG_CHAIN_PERF_EN
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] bub_cnt_q, bub_cnt_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        bub_cnt_d  = bub_cnt_q;
        if (hold[DEPTH-1] && hold_cnt_q != 32'hFFFF_FFFF) begin
            hold_cnt_d = hold_cnt_q + 32'd1;
        end
        if (!hold[DEPTH-1] && bub[DEPTH-1] && bub_cnt_q != 32'hFFFF_FFFF) begin
            bub_cnt_d = bub_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt_q <= '0;
            bub_cnt_q  <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            bub_cnt_q  <= bub_cnt_d;
        end
    end

    assign perf_hold_cnt   = hold_cnt_q;
    assign perf_bubble_cnt = bub_cnt_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain using three differently sized instances.
// Directed steps with a scoreboard queue for the streaming DEPTH=3 chain.
module tb_pipe_reg_chain;
    import pipe_reg_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] in_ctrl;
    logic [95:0] in_data;
    logic        in_stall;
    logic        in_cancel;

    logic [1:0]  stall_a, flush_a, valid_a;
    logic [2:0]  stall_b, flush_b, valid_b;
    logic [0:0]  stall_c, flush_c, valid_c;
    logic [15:0] ctrl_a, ctrl_b, ctrl_c;
    logic [95:0] data_a, data_b, data_c;

    int errors = 0;
    int checks = 0;
    logic [111:0] sb [$];

`ifdef PIPE_REG_CHAIN_PERF_EN
    logic [31:0] hc_a, bc_a, hc_b, bc_b, hc_c, bc_c;
    logic [31:0] hc_ref;
`endif

    pipe_reg_chain #(.DEPTH(2)) ua (
        .clock(clk), .reset(reset), .in_ctrl(in_ctrl), .in_data(in_data),
        .in_stall(in_stall), .in_cancel(in_cancel),
        .stall(stall_a), .flush(flush_a),
        .out_ctrl(ctrl_a), .out_data(data_a), .stage_valid(valid_a)
`ifdef PIPE_REG_CHAIN_PERF_EN
        , .perf_hold_cnt(hc_a), .perf_bubble_cnt(bc_a)
`endif
    );

    pipe_reg_chain #(.DEPTH(3)) ub (
        .clock(clk), .reset(reset), .in_ctrl(in_ctrl), .in_data(in_data),
        .in_stall(in_stall), .in_cancel(in_cancel),
        .stall(stall_b), .flush(flush_b),
        .out_ctrl(ctrl_b), .out_data(data_b), .stage_valid(valid_b)
`ifdef PIPE_REG_CHAIN_PERF_EN
        , .perf_hold_cnt(hc_b), .perf_bubble_cnt(bc_b)
`endif
    );

    pipe_reg_chain #(
        .DEPTH(1), .BUBBLE_MASK(16'h00FF), .CANCEL_MASK(16'h0001)
    ) uc (
        .clock(clk), .reset(reset), .in_ctrl(in_ctrl), .in_data(in_data),
        .in_stall(in_stall), .in_cancel(in_cancel),
        .stall(stall_c), .flush(flush_c),
        .out_ctrl(ctrl_c), .out_data(data_c), .stage_valid(valid_c)
`ifdef PIPE_REG_CHAIN_PERF_EN
        , .perf_hold_cnt(hc_c), .perf_bubble_cnt(bc_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops the oldest pushed item whenever the DEPTH=3 chain presents a valid output.
    task automatic pop_cmp();
        logic [111:0] e;
        if (valid_b[2]) begin
            if (sb.size() == 0) begin
                chk("sb_extra", {ctrl_b, data_b}, '0);
            end else begin
                e = sb.pop_front();
                chk("flow_ctrl", ctrl_b, e[111:96]);
                chk("flow_data", data_b, e[95:0]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_ctrl = '0; in_data = '0;
        in_stall = 1'b0; in_cancel = 1'b0;
        stall_a = '0; flush_a = '0;
        stall_b = '0; flush_b = '0;
        stall_c = '0; flush_c = '0;
        step(); step();
        chk("rst0_ctrl", ctrl_a, 16'h0);
        chk("rst0_data", data_a, 96'h0);
        chk("rst0_valid_a", valid_a, 2'b00);
        chk("rst0_valid_b", valid_b, 3'b000);
        chk("rst0_valid_c", valid_c, 1'b0);

        // Fill then reset
        reset = 1'b0; in_ctrl = 16'hFFFF; in_data = 96'h1;
        repeat (3) step();
        chk("fill_ctrl", ctrl_a, 16'hFFFF);
        chk("fill_data", data_a, 96'h1);
        chk("fill_valid", valid_a, 2'b11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_ctrl", ctrl_a, 16'h0);
        chk("rst_data", data_a, 96'h0);
        chk("rst_valid", valid_a, 2'b00);

        // Streaming through DEPTH=3
        for (int n = 1; n <= 8; n++) begin
            in_ctrl = 16'h8000 | 16'(n);
            in_data = 96'(n);
            sb.push_back({in_ctrl, in_data});
            step();
            if (n >= 3) chk("flow_valid", valid_b, 3'b111);
            else chk("flow_warm", valid_b[2], 1'b0);
            pop_cmp();
        end
        in_stall = 1'b1;
        repeat (3) begin
            step();
            pop_cmp();
        end
        chk("flow_drain", 32'(sb.size()), 32'd0);
        chk("flow_empty", valid_b, 3'b000);
        in_stall = 1'b0;

        // Stall propagation in DEPTH=2
        reset = 1'b1; step(); reset = 1'b0;
        in_ctrl = 16'h0B0B; in_data = 96'hB; step();
        in_ctrl = 16'h0A0A; in_data = 96'hA; step();
        chk("stl_pre", data_a, 96'hB);
`ifdef PIPE_REG_CHAIN_PERF_EN
        hc_ref = hc_a;
`endif
        stall_a = 2'b10;
        in_ctrl = 16'h0C0C; in_data = 96'hC;
        step();
        chk("stl_hold1", data_a, 96'hB);
        chk("stl_valid1", valid_a, 2'b11);
        step();
        chk("stl_hold2", data_a, 96'hB);
        chk("stl_ctrl2", ctrl_a, 16'h0B0B);
`ifdef PIPE_REG_CHAIN_PERF_EN
        chk("perf_hold2", hc_a, hc_ref + 32'd2);
`endif
        stall_a = 2'b00;
        in_ctrl = 16'h0D0D; in_data = 96'hD; step();
        chk("stl_relA", data_a, 96'hA);
        chk("stl_relA_c", ctrl_a, 16'h0A0A);
        in_ctrl = 16'h0E0E; in_data = 96'hE; step();
        chk("stl_noC", data_a, 96'hD);

        // Stall only stage 0: stage 1 takes a bubble carrying E's data
`ifdef PIPE_REG_CHAIN_PERF_EN
        hc_ref = hc_a;
`endif
        stall_a = 2'b01;
        in_ctrl = 16'h0F0F; in_data = 96'hF; step();
        chk("s0_bub_ctrl", ctrl_a, 16'h0);
        chk("s0_bub_data", data_a, 96'hE);
        chk("s0_bub_valid", valid_a, 2'b01);
`ifdef PIPE_REG_CHAIN_PERF_EN
        chk("perf_nohold", hc_a, hc_ref);
`endif
        stall_a = 2'b00;

        // Bubble mask on DEPTH=1
        in_stall = 1'b1; in_ctrl = 16'hABCD; in_data = 96'h55; step();
        chk("bm_ctrl", ctrl_c, 16'hAB00);
        chk("bm_valid", valid_c, 1'b0);
        chk("bm_data", data_c, 96'h55);
        in_stall = 1'b0;

        // Cancel, alone and with flush
        in_cancel = 1'b1; in_ctrl = 16'h0003; in_data = 96'h66; step();
        chk("cn_ctrl", ctrl_c, 16'h0002);
        chk("cn_valid", valid_c, 1'b1);
        flush_c = 1'b1; step();
        chk("cnfl_ctrl", ctrl_c, 16'h0002 & ~16'h00FF);
        chk("cnfl_valid", valid_c, 1'b0);
        in_ctrl = 16'h1203; step();
        chk("cnfl_ctrl2", ctrl_c, 16'h1200);
        in_cancel = 1'b0; flush_c = 1'b0;

        // Stall dominates flush
        in_ctrl = 16'h4321; in_data = 96'h88; step();
        chk("sf_pre", ctrl_c, 16'h4321);
        stall_c = 1'b1; flush_c = 1'b1;
        in_ctrl = 16'h7777; in_data = 96'h77; step();
        chk("sf_ctrl", ctrl_c, 16'h4321);
        chk("sf_data", data_c, 96'h88);
        chk("sf_valid", valid_c, 1'b1);
        stall_c = 1'b0; flush_c = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised pipeline-register chain for the MIPS32 core. It replaces hand-written single-stage bridges such as execute-to-memory and memory-to-writeback.
- Carries a control vector and a data vector through DEPTH stages.
- Per-stage stall (hold) and flush (bubble insertion) use a configurable mask. The mask selects which control bits are cleared on a bubble; the remaining bits pass through for exception purposes.
- A cancel input generalises move-conditional write suppression.

Parameters:
- CTRL_W, 16, control vector width (1..64)
- DATA_W, 96, data vector width (1..256)
- DEPTH, 1, number of register stages (1..4)
- BUBBLE_MASK, all ones, CTRL_W bits; 1 = bit forced to 0 when a bubble enters a stage, 0 = bit passes through
- CANCEL_MASK, 1, CTRL_W bits; bits forced to 0 when in_cancel is applied at entry

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- in_ctrl  in  CTRL_W  control from producing stage
- in_data  in  DATA_W  data from producing stage
- in_stall  in  1  producing stage stalled; inject bubble into stage 0
- in_cancel  in  1  clear CANCEL_MASK bits of the entering item (e.g. failed Movn/Movz)
- stall  in  DEPTH  stall[i]=1 holds stage i
- flush  in  DEPTH  flush[i]=1 turns the item entering stage i into a bubble
- out_ctrl  out  CTRL_W  control of last stage
- out_data  out  DATA_W  data of last stage
- stage_valid  out  DEPTH  per-stage valid (0 = bubble)

Behaviour:
- Clock and reset: one clock domain, clock; reset is synchronous and active-high.
- Reset: every stage's ctrl=0, data=0, valid=0, so out_ctrl=0, out_data=0, stage_valid=0. Reset has priority over all other inputs. Reset mid-stall empties the chain; there is no replay.
- Hold propagation (combinational):
  - hold[DEPTH-1] = stall[DEPTH-1]
  - hold[i] = stall[i] | hold[i+1]
- Per stage i, on each rising edge, first match wins:
  1. hold[i]: ctrl, data and valid all keep their value.
  2. Entry is a bubble. For i=0 the condition is in_stall | flush[0]; for i>0 it is hold[i-1] | flush[i]. Result:
     - ctrl = src_ctrl & ~BUBBLE_MASK
     - data = src_data
     - valid = 0
  3. Otherwise: ctrl = src_ctrl, data = src_data, valid = src_valid.
- Source for stage 0:
  - src_ctrl = in_cancel ? (in_ctrl & ~CANCEL_MASK) : in_ctrl
  - src_data = in_data
  - src_valid = 1
- Source for stage i>0: the outputs of stage i-1.
- Cancel and bubble together: both masks apply; valid=0.
- Latency: DEPTH cycles with no stalls. Throughput: one item per cycle.
- Data is never cleared except by reset. Bubbles preserve the restart PC and similar data for exception reporting.
- Stall dominates flush at the same stage: a held stage is not bubbled even if flush[i]=1.
- No internal state machine beyond the registers and valid bits. No item is lost or duplicated: an item leaves stage i-1 only when stage i captures it.

Optional Feature:
- Macro: PIPE_REG_CHAIN_PERF_EN.
- Defined:
  - Adds output perf_hold_cnt (32 bits): counts cycles with hold[DEPTH-1]=1.
  - Adds output perf_bubble_cnt (32 bits): counts cycles in which the last stage captures a bubble.
  - Both counters saturate at 0xFFFFFFFF and are cleared by reset.
- Undefined: the ports and counters are absent, and the behaviour is otherwise identical.

Decomposition:
- Package pipe_reg_pkg holds:
  - default widths
  - the maximum DEPTH constant
  - helper function mask_ctrl(ctrl, mask)
- Sub-module pipe_reg_slot implements one stage:
  - ports: hold, bubble, src_ctrl/data/valid
  - parameters: CTRL_W, DATA_W, BUBBLE_MASK
- Top level instantiates pipe_reg_slot in a generate loop and computes the hold chain.

Test Plan:
- Reset: set DEPTH=2 and drive in_ctrl=16'hFFFF, in_data=96'h1 for 3 cycles; assert reset for 1 cycle. Required: next cycle out_ctrl=0, out_data=0, stage_valid=2'b00.
- Flow: set DEPTH=3 and stream in_data=1,2,3,... with valid ctrl. Required: out_data equals the input from 3 cycles earlier, and stage_valid=3'b111 from cycle 3 onward.
- Stall propagation: set DEPTH=2 and hold stall[1]=1 for 2 cycles with items A in stage 0 and B in stage 1. Required:
  - B stays at the output.
  - A stays in stage 0.
  - The input item is not accepted.
  - On release, B departs and A advances.
- Bubble mask: set BUBBLE_MASK=16'h00FF and in_ctrl=16'hABCD with in_stall=1. Required: stage 0 ctrl=16'hAB00, valid=0, and data passes.
- Cancel: set CANCEL_MASK=16'h0001 and in_ctrl=16'h0003 with in_cancel=1. Required: captured ctrl=16'h0002, valid=1. With flush[0]=1 also asserted, ctrl=16'h0002 & ~BUBBLE_MASK and valid=0.
- Stall vs flush: stall[0]=1 and flush[0]=1 in the same cycle. Required: stage 0 unchanged. With PIPE_REG_CHAIN_PERF_EN defined, perf_hold_cnt increments only when stall[DEPTH-1] is asserted.
